// File: rtl/snoopy_bus_arbiter_if.sv
// Snoopy bus arbitration signal bundle shared by the caches and the arbiter.
// master: cache side (drives requests); slave: arbiter side (drives grants).
interface snoopy_bus_arbiter_if #(
    parameter int NUMBER_OF_CACHES = 4
);
    localparam int OW = $clog2(NUMBER_OF_CACHES);

    logic [NUMBER_OF_CACHES-1:0] busRequest;
    logic [NUMBER_OF_CACHES-1:0] busGrant;
    logic [OW-1:0]               busOwner;
    logic                        busBusy;
    logic [NUMBER_OF_CACHES-1:0] snoopRequest;
    logic [NUMBER_OF_CACHES-1:0] snoopGrant;
    logic                        holdTimeout;

    modport master (
        output busRequest, snoopRequest,
        input  busGrant, busOwner, busBusy, snoopGrant, holdTimeout
    );

    modport slave (
        input  busRequest, snoopRequest,
        output busGrant, busOwner, busBusy, snoopGrant, holdTimeout
    );
endinterface

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin snoopy bus arbiter with optional ownership limit and snoop
// responder selection. Ports: clock, reset (sync, active-high), bus (slave).
module snoopy_bus_arbiter #(
    parameter int NUMBER_OF_CACHES = 4,
    parameter int MAX_HOLD_CYCLES  = 0
) (
    input logic                clock,
    input logic                reset,
    snoopy_bus_arbiter_if.slave bus
);
    localparam int N  = NUMBER_OF_CACHES;
    localparam int OW = $clog2(N);
    localparam int CW = (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
    localparam logic [OW:0]   NUM_C     = N[OW:0];
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD_CYCLES > 0) ?
                                          CW'(MAX_HOLD_CYCLES - 1) : '0;
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

    state_t        r_state, w_state;
    logic [OW-1:0] r_ptr, w_ptr;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [N-1:0]  r_busGrant, w_busGrant;
    logic [OW-1:0] r_busOwner, w_busOwner;
    logic [N-1:0]  r_snoopGrant, w_snoopGrant;
    logic          r_holdTimeout, w_holdTimeout;

    logic [OW:0]   w_pick;
    logic [OW-1:0] w_win;
    logic [OW:0]   w_inc;
    logic [N-1:0]  w_cand;
    logic [N-1:0]  w_low;

    // Search upward from ptr with wrap; MSB of result flags a hit.
    function automatic logic [OW:0] rr_pick(
        input logic [N-1:0]  req,
        input logic [OW-1:0] ptr
    );
        logic [OW:0]   s;
        logic          found;
        logic [OW-1:0] win;
        s     = {1'b0, ptr};
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[s[OW-1:0]]) begin
                found = 1'b1;
                win   = s[OW-1:0];
            end
            s = s + 1'b1;
            if (s == NUM_C) s = '0;
        end
        return {found, win};
    endfunction

    always_comb begin
        w_pick = rr_pick(bus.busRequest, r_ptr);
        w_win  = w_pick[OW-1:0];
        w_inc  = {1'b0, w_win} + 1'b1;
        // Owner bit masked via its one-hot grant; isolate lowest snooper.
        w_cand = bus.snoopRequest & ~r_busGrant;
        w_low  = w_cand & (~w_cand + ONE);

        w_state       = r_state;
        w_ptr         = r_ptr;
        w_cnt         = r_cnt;
        w_busGrant    = r_busGrant;
        w_busOwner    = r_busOwner;
        w_snoopGrant  = '0;
        w_holdTimeout = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick[OW]) begin
                    w_state    = GRANTED;
                    w_busGrant = ONE << w_win;
                    w_busOwner = w_win;
                    w_ptr      = (w_inc == NUM_C) ? '0 : w_inc[OW-1:0];
                    w_cnt      = '0;
                end
            end
            GRANTED: begin
                if ((bus.busRequest & r_busGrant) == '0) begin
                    w_state    = RELEASE;
                    w_busGrant = '0;
                    w_busOwner = '0;
                end else if (MAX_HOLD_CYCLES != 0 && r_cnt == HOLD_LAST) begin
                    w_state       = RELEASE;
                    w_busGrant    = '0;
                    w_busOwner    = '0;
                    w_holdTimeout = 1'b1;
                end else begin
                    w_cnt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                    // Keep the current snooper until its request drops.
                    if ((r_snoopGrant & bus.snoopRequest) != '0)
                        w_snoopGrant = r_snoopGrant;
                    else
                        w_snoopGrant = w_low;
                end
            end
            RELEASE: w_state = IDLE;
            default: begin
                w_state    = IDLE;
                w_busGrant = '0;
                w_busOwner = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_busGrant    <= '0;
            r_busOwner    <= '0;
            r_snoopGrant  <= '0;
            r_holdTimeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_ptr         <= w_ptr;
            r_cnt         <= w_cnt;
            r_busGrant    <= w_busGrant;
            r_busOwner    <= w_busOwner;
            r_snoopGrant  <= w_snoopGrant;
            r_holdTimeout <= w_holdTimeout;
        end
    end

    assign bus.busGrant    = r_busGrant;
    assign bus.busOwner    = r_busOwner;
    assign bus.busBusy     = |r_busGrant;
    assign bus.snoopGrant  = r_snoopGrant;
    assign bus.holdTimeout = r_holdTimeout;
endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Self-checking bench for snoopy_bus_arbiter (4 caches, hold limit 5).
// Vector table, corner sequences, then random stimulus against a model.
module tb_snoopy_bus_arbiter;
    localparam int N    = 4;
    localparam int MAXH = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;

    snoopy_bus_arbiter_if #(.NUMBER_OF_CACHES(N)) bus ();

    snoopy_bus_arbiter #(
        .NUMBER_OF_CACHES(N),
        .MAX_HOLD_CYCLES(MAXH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] snp;
        logic [3:0] gnt;
        logic [1:0] own;
        logic [3:0] sg;
        logic       to;
    } vec_t;

    vec_t tbl [14];

    // Model state: owner index or -1, round-robin start, cycles held,
    // turnaround cycles still to wait, selected snooper or -1.
    int   m_owner, m_ptr, m_held, m_dead, m_sel;
    logic m_to;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [11:0] mk(input logic [3:0] g, input logic [1:0] o,
                                       input logic [3:0] s, input logic t);
        return {g, o, (g != 4'b0000), s, t};
    endfunction

    function automatic logic [11:0] dut_out();
        return {bus.busGrant, bus.busOwner, bus.busBusy, bus.snoopGrant, bus.holdTimeout};
    endfunction

    task automatic check(input string nm, input logic [11:0] exp);
        logic [11:0] got;
        got = dut_out();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%b own=%0d busy=%b sg=%b to=%b, want gnt=%b own=%0d busy=%b sg=%b to=%b",
                     nm, got[11:8], got[7:6], got[5], got[4:1], got[0],
                     exp[11:8], exp[7:6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    function automatic logic bitof(input logic [3:0] v, input int i);
        logic [1:0] ix;
        ix = i[1:0];
        return v[ix];
    endfunction

    task automatic model_edge(input logic rst, input logic [3:0] req, input logic [3:0] snp);
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_dead = 0; m_sel = -1;
        end else if (m_owner >= 0) begin
            m_held++;
            if (!bitof(req, m_owner)) begin
                m_owner = -1; m_dead = 1; m_sel = -1;
            end else if (m_held == MAXH) begin
                m_owner = -1; m_dead = 1; m_sel = -1; m_to = 1'b1;
            end else if (!(m_sel >= 0 && bitof(snp, m_sel))) begin
                m_sel = -1;
                for (int i = 0; i < N; i++)
                    if (m_sel < 0 && i != m_owner && bitof(snp, i)) m_sel = i;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && bitof(req, (m_ptr + k) % N)) m_owner = (m_ptr + k) % N;
            if (m_owner >= 0) begin
                m_ptr = (m_owner + 1) % N; m_held = 0; m_sel = -1;
            end
        end
    endtask

    function automatic logic [11:0] model_out();
        logic [3:0] g;
        logic [3:0] s;
        logic [1:0] o;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        o = (m_owner >= 0) ? m_owner[1:0] : 2'd0;
        s = (m_sel >= 0) ? (4'b0001 << m_sel) : 4'b0000;
        return mk(g, o, s, m_to);
    endfunction

    initial begin
        int got_order [5];
        int exp_order [5];
        int g_n, held, hi, to_n, nxt;
        logic [3:0] r, s;

        tbl[0]  = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 4'b0000, 1'b0};
        tbl[3]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 4'b0000, 1'b0};
        tbl[6]  = '{1'b0, 4'b1000, 4'b1111, 4'b1000, 2'd3, 4'b0001, 1'b0};
        tbl[7]  = '{1'b0, 4'b1000, 4'b1110, 4'b1000, 2'd3, 4'b0010, 1'b0};
        tbl[8]  = '{1'b0, 4'b1000, 4'b0011, 4'b1000, 2'd3, 4'b0010, 1'b0};
        tbl[9]  = '{1'b1, 4'b1000, 4'b0011, 4'b0000, 2'd0, 4'b0000, 1'b0};
        tbl[10] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1'b0};
        tbl[11] = '{1'b0, 4'b0001, 4'b0111, 4'b0001, 2'd0, 4'b0010, 1'b0};
        tbl[12] = '{1'b0, 4'b0001, 4'b0101, 4'b0001, 2'd0, 4'b0100, 1'b0};
        tbl[13] = '{1'b0, 4'b0000, 4'b0101, 4'b0000, 2'd0, 4'b0000, 1'b0};
        exp_order = '{0, 1, 2, 3, 0};

        bus.busRequest   = '0;
        bus.snoopRequest = '0;

        for (int i = 0; i < 14; i++) begin
            reset            = tbl[i].rst;
            bus.busRequest   = tbl[i].req;
            bus.snoopRequest = tbl[i].snp;
            step();
            check($sformatf("vec%0d", i), mk(tbl[i].gnt, tbl[i].own, tbl[i].sg, tbl[i].to));
        end

        // Fair rotation: every owner drops after three granted cycles.
        reset = 1'b1; bus.busRequest = '0; bus.snoopRequest = '0;
        step();
        reset = 1'b0; bus.busRequest = 4'b1111;
        g_n = 0; held = 0;
        for (int c = 0; c < 60 && g_n < 5; c++) begin
            step();
            if (bus.busGrant != 4'b0000) begin
                if (held == 0) begin
                    got_order[g_n] = int'(bus.busOwner);
                    g_n++;
                end
                held++;
                if (held == 3) bus.busRequest = bus.busRequest & ~bus.busGrant;
            end else begin
                held = 0;
                bus.busRequest = 4'b1111;
            end
        end
        check_int("rr_grants_seen", g_n, 5);
        for (int k = 0; k < 5; k++)
            if (k < g_n) check_int($sformatf("rr_order%0d", k), got_order[k], exp_order[k]);

        // Hold limit: cache 2 keeps requesting, cache 3 waits.
        reset = 1'b1; bus.busRequest = '0;
        step();
        reset = 1'b0; bus.busRequest = 4'b1100;
        hi = 0; to_n = 0; nxt = -1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.busGrant == 4'b0100) hi++;
            if (bus.holdTimeout) begin
                to_n++;
                check_int("timeout_grant_low", int'(bus.busGrant), 0);
            end
            if (bus.busGrant != 4'b0000 && bus.busGrant != 4'b0100 && nxt < 0)
                nxt = int'(bus.busOwner);
        end
        check_int("hold_cycles", hi, 5);
        check_int("timeout_pulses", to_n, 1);
        check_int("after_timeout_owner", nxt, 3);

        // Random traffic against the reference model.
        reset = 1'b1; bus.busRequest = '0; bus.snoopRequest = '0;
        step();
        model_edge(1'b1, 4'b0000, 4'b0000);
        check("rand_reset", model_out());
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(59) == 0);
            r = bus.busRequest ^ (4'($urandom) & 4'($urandom));
            s = bus.snoopRequest ^ (4'($urandom) & 4'($urandom));
            bus.busRequest   = r;
            bus.snoopRequest = s;
            step();
            model_edge(reset, r, s);
            check($sformatf("rand%0d", c), model_out());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snoopy_bus_arbiter.md
SNOOPY_BUS_ARBITER -- requirements
Module: snoopy_bus_arbiter

Interface
REQ-001 SHALL have parameter NUMBER_OF_CACHES, default 4, number of cache controllers sharing the snoopy bus (legal range 2..16).
REQ-002 SHALL have parameter MAX_HOLD_CYCLES, default 0, bus-ownership cycle limit; 0 disables the limit.
REQ-003 SHALL have port clock  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port busRequest  input  NUMBER_OF_CACHES  bit i set while cache i's cpu controller has a bus command pending.
REQ-006 SHALL have port busGrant  output  NUMBER_OF_CACHES  one-hot or zero; bit i grants the bus to cache i.
REQ-007 SHALL have port busOwner  output  $clog2(NUMBER_OF_CACHES)  index of granted cache; 0 when no grant.
REQ-008 SHALL have port busBusy  output  1  high while any busGrant bit is set.
REQ-009 SHALL have port snoopRequest  input  NUMBER_OF_CACHES  bit i set while cache i snoop-hits the current bus address.
REQ-010 SHALL have port snoopGrant  output  NUMBER_OF_CACHES  one-hot or zero; selects the single snooper that drives data/state response.
REQ-011 SHALL have port holdTimeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 SHALL implement FSM states IDLE, GRANTED, RELEASE; all outputs registered.
REQ-013 IDLE: if busRequest != 0, SHALL select winner by round-robin starting at pointer, searching upward with wrap at NUMBER_OF_CACHES-1 -> 0, assert busGrant[winner] next cycle, go GRANTED; else stay IDLE, busGrant = 0.
REQ-014 Grant latency from request in IDLE SHALL be exactly 1 cycle.
REQ-015 On grant to winner w, pointer SHALL become (w+1) mod NUMBER_OF_CACHES.
REQ-016 GRANTED: grant SHALL be held while busRequest[owner] = 1; other requests SHALL NOT preempt.
REQ-017 GRANTED: when busRequest[owner] = 0, SHALL deassert busGrant next cycle and go RELEASE.
REQ-018 RELEASE: SHALL last exactly 1 cycle with busGrant = 0 (bus turnaround), then IDLE; new grant earliest 1 cycle after that, i.e. 2 dead cycles between owners.
REQ-019 Hold counter (width $clog2(MAX_HOLD_CYCLES+1), min 1) SHALL clear on entry to GRANTED and increment each GRANTED cycle; saturate, no wrap.
REQ-020 If MAX_HOLD_CYCLES != 0 and counter reaches MAX_HOLD_CYCLES-1 while owner still requests, SHALL revoke grant next cycle, pulse holdTimeout for that cycle, go RELEASE.
REQ-021 Revoked owner SHALL be treated as lowest priority on next arbitration (pointer already past it).
REQ-022 snoopGrant SHALL be nonzero only in GRANTED; selects lowest index i with snoopRequest[i] = 1 and i != owner; registered, 1-cycle latency.
REQ-023 snoopGrant SHALL be held stable while the selected snoopRequest bit stays high and state is GRANTED; reselect only after that bit drops.
REQ-024 Owner's own snoopRequest bit SHALL be ignored.
REQ-025 busOwner SHALL update in the same cycle as busGrant; busBusy = |busGrant.
REQ-026 busGrant and snoopGrant SHALL never have more than one bit set.

Reset
REQ-027 On reset = 1 at a clock edge: state IDLE, pointer 0, hold counter 0, busGrant 0, busOwner 0, busBusy 0, snoopGrant 0, holdTimeout 0.
REQ-028 Reset asserted mid-grant SHALL drop busGrant and snoopGrant the next edge without RELEASE cycle; requests sampled during reset ignored.
REQ-029 First grant after reset release SHALL favour cache 0 when multiple requests pending.

Verification
REQ-030 N=4, reset then busRequest=4'b1010 held -> busGrant=4'b0010 one cycle later; pointer=2.
REQ-031 Owner 1 drops request while 4'b1000 pending -> busGrant 0 for two cycles (RELEASE, IDLE), then 4'b1000; pointer wraps to 0.
REQ-032 All four request continuously, each dropping after 3 granted cycles -> grant order 0,1,2,3,0; no bit starved.
REQ-033 MAX_HOLD_CYCLES=5, cache 2 holds request 10 cycles -> grant high exactly 5 cycles, holdTimeout pulses once, next grant to 3 if requesting.
REQ-034 Owner 0 granted, snoopRequest=4'b0111 -> snoopGrant=4'b0010 next cycle; bit 1 drops -> snoopGrant=4'b0100 one cycle later.
REQ-035 Reset pulsed during GRANTED with owner 3 -> all outputs zero next edge; after release, request 4'b1001 -> grant to 0.
